// File: rtl/button_request_gen.sv
// Button front end: 2-flop sync + tick-based debounce, press/auto-repeat events, 4-phase req/ack move channels.
// Build option: define AUTO_REPEAT_EN to instantiate the left/right auto-repeat FSMs.

module brg_debounce #(
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic tick,
  input  logic raw,
  output logic deb
);
  localparam int SW = $clog2(DEBOUNCE_TICKS + 1);

  logic [1:0]    sync;
  logic [SW-1:0] stb;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync <= '0;
      stb  <= '0;
      deb  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == deb) stb <= '0;
      else if (tick) begin
        // toggle on the tick that would bring stb to DEBOUNCE_TICKS
        if (stb == SW'(DEBOUNCE_TICKS - 1)) begin
          deb <= ~deb;
          stb <= '0;
        end else stb <= stb + 1'b1;
      end
    end
  end
endmodule

`ifdef AUTO_REPEAT_EN
module brg_repeat #(
  parameter int REPEAT_DELAY = 300,
  parameter int REPEAT_RATE  = 100
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic tick,
  input  logic deb,
  input  logic press,
  output logic evt
);
  localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rep_state_t;

  rep_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= R_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    evt      = 1'b0;
    case (state)
      R_IDLE: if (press) begin
        state_nx = R_DELAY;
        cnt_nx   = CW'(REPEAT_DELAY);
      end
      R_DELAY, R_REPEAT: begin
        if (!deb) state_nx = R_IDLE;
        else if (tick) begin
          // the tick that takes the count to zero fires the repeat
          if (cnt <= CW'(1)) begin
            evt      = 1'b1;
            state_nx = R_REPEAT;
            cnt_nx   = CW'(REPEAT_RATE);
          end else cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = R_IDLE;
    endcase
  end
endmodule
`endif

module brg_channel (
  input  logic CLK,
  input  logic RST_N,
  input  logic evt,
  input  logic can,
  input  logic ack,
  output logic req,
  output logic drop
);
  typedef enum logic [1:0] {C_IDLE, C_REQ, C_WAITLOW} ch_state_t;

  ch_state_t state, state_nx;

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= C_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    drop     = 1'b0;
    case (state)
      C_IDLE: if (evt) begin
        if (can) state_nx = C_REQ;
        else     drop     = 1'b1;
      end
      C_REQ: begin
        if (ack) state_nx = C_WAITLOW;
        drop = evt;
      end
      C_WAITLOW: begin
        if (!ack) state_nx = C_IDLE;
        drop = evt;
      end
      default: state_nx = C_IDLE;
    endcase
  end

  assign req = (state == C_REQ);
endmodule

module button_request_gen #(
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_DELAY   = 300,
  parameter int REPEAT_RATE    = 100
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       buttenL,
  input  logic       buttenR,
  input  logic       buttenT,
  input  logic       buttenD,
  input  logic       can_left,
  input  logic       can_right,
  input  logic       can_rotate,
  input  logic       ack_left,
  input  logic       ack_right,
  input  logic       ack_turn,
  output logic       req_left,
  output logic       req_right,
  output logic       req_turn,
  output logic       down_hold,
  output logic [7:0] drop_cnt
);
  localparam int NUM_BTN  = 4;   // {D, T, R, L}
  localparam int NUM_MOVE = 3;   // {T, R, L}
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  logic [NUM_BTN-1:0]    raw, deb;
  logic [NUM_MOVE-1:0]   deb_q, press, evt, can, ack, req, drop;
  logic [1:0]            rep_evt;
  logic [1:0]            n_drop;
  logic [8:0]            drop_sum;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  assign raw = {buttenD, buttenT, buttenR, buttenL};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    brg_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb (
      .CLK(CLK), .RST_N(RST_N), .tick(tick), .raw(raw[g]), .deb(deb[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) deb_q <= '0;
    else        deb_q <= deb[NUM_MOVE-1:0];
  end

  assign press = deb[NUM_MOVE-1:0] & ~deb_q;

`ifdef AUTO_REPEAT_EN
  for (genvar g = 0; g < 2; g++) begin : g_rep
    brg_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep (
      .CLK(CLK), .RST_N(RST_N), .tick(tick), .deb(deb[g]), .press(press[g]), .evt(rep_evt[g])
    );
  end
`else
  assign rep_evt = '0;
  // repeat timing has no effect in this build; keep the parameters referenced
  if (REPEAT_DELAY > 0 && REPEAT_RATE > 0) begin : g_rep_cfg
  end
`endif

  assign evt = press | {1'b0, rep_evt};
  assign can = {can_rotate, can_right, can_left};
  assign ack = {ack_turn, ack_right, ack_left};

  for (genvar g = 0; g < NUM_MOVE; g++) begin : g_ch
    brg_channel u_ch (
      .CLK(CLK), .RST_N(RST_N), .evt(evt[g]), .can(can[g]), .ack(ack[g]),
      .req(req[g]), .drop(drop[g])
    );
  end

  assign {req_turn, req_right, req_left} = req;
  assign down_hold = deb[3];

  // up to three channels may drop in the same cycle
  assign n_drop   = 2'({1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]});
  assign drop_sum = {1'b0, drop_cnt} + {7'd0, n_drop};

  always_ff @(posedge CLK) begin
    if (!RST_N) drop_cnt <= '0;
    else        drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end
endmodule

// File: tb/tb_button_request_gen.sv
// Directed bench for button_request_gen: table of press scenarios plus handshake, repeat, drop and reset sequences.
module tb_button_request_gen;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST_N;
  logic       bL, bR, bT, bD;
  logic       can_l, can_r, can_t;
  logic       ack_l, ack_r, ack_t;
  logic       req_left, req_right, req_turn, down_hold;
  logic [7:0] drop_cnt;

  button_request_gen #(.TICK_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_DELAY(8), .REPEAT_RATE(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .buttenL(bL), .buttenR(bR), .buttenT(bT), .buttenD(bD),
    .can_left(can_l), .can_right(can_r), .can_rotate(can_t),
    .ack_left(ack_l), .ack_right(ack_r), .ack_turn(ack_t),
    .req_left(req_left), .req_right(req_right), .req_turn(req_turn),
    .down_hold(down_hold), .drop_cnt(drop_cnt)
  );

  // Responder: auto mode acks one cycle after req, otherwise manual levels.
  logic       auto_ack;
  logic [2:0] man_ack;
  logic [2:0] ack_dly;
  logic [2:0] reqv;
  assign reqv = {req_turn, req_right, req_left};
  always @(posedge CLK) ack_dly <= reqv;
  always_comb begin
    ack_l = auto_ack ? ack_dly[0] : man_ack[0];
    ack_r = auto_ack ? ack_dly[1] : man_ack[1];
    ack_t = auto_ack ? ack_dly[2] : man_ack[2];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_btn(input logic [3:0] m);
    {bD, bT, bR, bL} = m;
  endtask

  task automatic set_can(input logic [2:0] c);
    {can_t, can_r, can_l} = c;
  endtask

  // Reset for two cycles; returns at a negedge with RST_N still low.
  task automatic hold_reset();
    RST_N = 1'b0;
    set_btn(4'b0000);
    cyc(2);
  endtask

  int         rise [3];
  logic [2:0] prev;
  logic       dh_seen;

  task automatic run_count(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(1);
      for (int i = 0; i < 3; i++) if (reqv[i] && !prev[i]) rise[i]++;
      if (down_hold) dh_seen = 1'b1;
      prev = reqv;
    end
  endtask

  task automatic clear_count();
    for (int i = 0; i < 3; i++) rise[i] = 0;
    prev    = reqv;
    dh_seen = 1'b0;
  endtask

  task automatic wait_req(input int idx, input int bound, output int n);
    n = 0;
    while (n < bound && !reqv[idx]) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic press(input logic [3:0] m, input int hold, input int gap);
    set_btn(m);
    cyc(hold);
    set_btn(4'b0000);
    cyc(gap);
  endtask

  typedef struct {
    string      name;
    logic [3:0] btn;   // {D, T, R, L}
    logic [2:0] can;   // {T, R, L}
    int         hold;
    int         exp_l, exp_r, exp_t;
    logic       exp_dh;
    logic [7:0] exp_drop;
  } vec_t;

  vec_t vecs [9];
  int   n;
  int   nr;
  int   t [8];

  initial begin
    vecs[0] = '{"glitch_l", 4'b0001, 3'b111,  6, 0, 0, 0, 1'b0, 8'd0};
    vecs[1] = '{"press_l",  4'b0001, 3'b111, 20, 1, 0, 0, 1'b0, 8'd0};
    vecs[2] = '{"press_r",  4'b0010, 3'b111, 20, 0, 1, 0, 1'b0, 8'd0};
    vecs[3] = '{"press_t",  4'b0100, 3'b111, 20, 0, 0, 1, 1'b0, 8'd0};
    vecs[4] = '{"press_d",  4'b1000, 3'b111, 20, 0, 0, 0, 1'b1, 8'd0};
    vecs[5] = '{"press_lr", 4'b0011, 3'b111, 20, 1, 1, 0, 1'b0, 8'd0};
    vecs[6] = '{"gate_l",   4'b0001, 3'b110, 20, 0, 0, 0, 1'b0, 8'd1};
    vecs[7] = '{"gate_t",   4'b0101, 3'b011, 20, 1, 0, 0, 1'b0, 8'd1};
    vecs[8] = '{"glitch_r", 4'b0010, 3'b111,  6, 0, 0, 0, 1'b0, 8'd0};

    RST_N = 1'b0; auto_ack = 1'b0; man_ack = 3'b000;
    set_btn(4'b0000); set_can(3'b111);

    // Reset with every button held: outputs stay low, one press after debounce
    @(negedge CLK);
    set_btn(4'b1111);
    cyc(3);
    chk("rst_req_left", req_left, 0);
    chk("rst_req_right", req_right, 0);
    chk("rst_req_turn", req_turn, 0);
    chk("rst_down_hold", down_hold, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    RST_N = 1'b1;
    wait_req(0, 40, n);
    chk("rst_press_latency_12_15", (n >= 12 && n <= 15), 1);
    chk("rst_press_req_right", req_right, 1);
    chk("rst_press_req_turn", req_turn, 1);
    chk("rst_press_down_hold", down_hold, 1);

    // Table: reset, hold buttons, release, then count request pulses
    auto_ack = 1'b1;
    for (int v = 0; v < 9; v++) begin
      hold_reset();
      set_can(vecs[v].can);
      clear_count();
      RST_N = 1'b1;
      set_btn(vecs[v].btn);
      run_count(vecs[v].hold);
      set_btn(4'b0000);
      run_count(40);
      chk({vecs[v].name, "_rise_l"}, rise[0], vecs[v].exp_l);
      chk({vecs[v].name, "_rise_r"}, rise[1], vecs[v].exp_r);
      chk({vecs[v].name, "_rise_t"}, rise[2], vecs[v].exp_t);
      chk({vecs[v].name, "_down_hold"}, dh_seen, vecs[v].exp_dh);
      chk({vecs[v].name, "_drop_cnt"}, drop_cnt, vecs[v].exp_drop);
    end
    set_can(3'b111);

    // Handshake timing with manual ack two cycles after req
    auto_ack = 1'b0;
    hold_reset();
    RST_N = 1'b1;
    set_btn(4'b0001);
    wait_req(0, 40, n);
    chk("hs_req_seen", req_left, 1);
    cyc(2);
    man_ack[0] = 1'b1;
    chk("hs_req_before_ack", req_left, 1);
    cyc(1);
    chk("hs_req_fall", req_left, 0);
    man_ack[0] = 1'b0;
    set_btn(4'b0000);
    clear_count();
    run_count(40);
    chk("hs_no_second_req", rise[0], 0);

    // Long hold on right with fast ack
    auto_ack = 1'b1;
    hold_reset();
    RST_N = 1'b1;
    set_btn(4'b0010);
    prev = reqv;
    nr = 0;
    for (int k = 0; k < 200; k++) begin
      cyc(1);
      if (reqv[1] && !prev[1]) begin
        if (nr < 8) t[nr] = k;
        nr++;
      end
      prev = reqv;
    end
`ifdef AUTO_REPEAT_EN
    chk("rep_at_least_3", (nr >= 3), 1);
    chk("rep_first_gap", t[1] - t[0], 32);
    chk("rep_next_gap", t[2] - t[1], 16);
    chk("rep_third_gap", t[3] - t[2], 16);
`else
    chk("hold_single_req", nr, 1);
`endif
    set_btn(4'b0000);
    cyc(30);
    clear_count();
    run_count(60);
    chk("release_no_req", rise[1], 0);

    // No ack on turn: second press dropped, then saturate the drop counter
    auto_ack = 1'b0;
    man_ack  = 3'b000;
    hold_reset();
    RST_N = 1'b1;
    press(4'b0100, 24, 30);
    chk("noack_req_turn_1", req_turn, 1);
    chk("noack_drop_0", drop_cnt, 0);
    press(4'b0100, 24, 30);
    chk("noack_req_turn_2", req_turn, 1);
    chk("noack_drop_1", drop_cnt, 1);
    for (int k = 0; k < 253; k++) press(4'b0100, 24, 30);
    chk("drop_254", drop_cnt, 254);
    for (int k = 0; k < 46; k++) press(4'b0100, 24, 30);
    chk("drop_sat_255", drop_cnt, 255);
    chk("noack_req_turn_end", req_turn, 1);

    // can_left falls while req pending: req is held
    hold_reset();
    RST_N = 1'b1;
    set_btn(4'b0001);
    wait_req(0, 40, n);
    chk("gate_req_seen", req_left, 1);
    can_l = 1'b0;
    cyc(10);
    chk("gate_req_held", req_left, 1);
    chk("gate_no_drop", drop_cnt, 0);

    // One-cycle reset mid-handshake, then the held button presses again
    RST_N = 1'b0;
    cyc(1);
    RST_N = 1'b1;
    chk("rstmid_req_low", req_left, 0);
    can_l = 1'b1;
    wait_req(0, 40, n);
    chk("rstmid_req_again", req_left, 1);
    set_btn(4'b0000);
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_request_gen.md
# button_request_gen

Input-side front end for the Tetris game. It synchronizes and debounces the four raw push buttons (left, right, turn, down). It turns presses into one request per move, and for left/right optionally auto-repeats while a button is held. Each move is delivered to the game core over a 4-phase req/ack handshake, so no move is lost or duplicated across clock domains or game-loop phases. It sits between the board buttons and the game state machine and replaces the ad-hoc 5 Hz button sampling.

## Interface
Parameters:
- TICK_DIV, 50000: CLK cycles per debounce/repeat tick (1 kHz at 50 MHz).
- DEBOUNCE_TICKS, 20: consecutive stable ticks needed to accept a level change.
- REPEAT_DELAY, 300: ticks held before the first auto-repeat.
- REPEAT_RATE, 100: ticks between auto-repeats.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST_N  in  1  synchronous, active-low reset.
- buttenL / buttenR / buttenT / buttenD  in  1 each  raw asynchronous buttons, active-high.
- can_left / can_right / can_rotate  in  1 each  game permission; an event is accepted only if the matching bit is 1 in the event cycle.
- ack_left / ack_right / ack_turn  in  1 each  game acknowledge.
- req_left / req_right / req_turn  out  1 each  move request, level.
- down_hold  out  1  debounced level of buttenD.
- drop_cnt  out  8  saturating count of dropped events.

## Operation
- **Synchronizer:** 2-flop synchronizer on each button.
- **Tick:** counter 0..TICK_DIV-1. `tick` is a 1-cycle pulse when the counter wraps.
- **Debounce, per button:** state `deb`, counter `stb`.
  - If sync == deb, stb = 0.
  - Else, on each tick, stb++. When stb reaches DEBOUNCE_TICKS, deb toggles and stb = 0.
- **Press event:** a rising edge of deb for L/R/T produces one event.
- **Repeat FSM, L and R only:**
  - States are IDLE, DELAY, REPEAT.
  - IDLE → DELAY on press event; load counter with REPEAT_DELAY.
  - DELAY: decrement on each tick. At 0, emit an event, go to REPEAT, and load REPEAT_RATE.
  - REPEAT: decrement on each tick. At 0, emit an event and reload.
  - Falling edge of deb → IDLE from any state.
  - Turn never repeats.
- **Channel FSM, per move:**
  - States are IDLE, REQ, WAITLOW.
  - IDLE → REQ on an accepted event (event && can_x); req_x = 1.
  - REQ → WAITLOW when ack_x = 1; req_x = 0.
  - WAITLOW → IDLE when ack_x = 0.
  - An event arriving in REQ or WAITLOW is dropped.
  - An event arriving while can_x = 0 is dropped.
  - Every drop increments drop_cnt, which saturates at 255.
- **Channel independence:** channels are independent. Simultaneous left and right events both raise requests; the game arbitrates.
- **Same-cycle event and ack in REQ:** the channel goes to WAITLOW and the event is dropped and counted.
- **can_x changes while a request is pending:** req is not withdrawn.

## Timing
- **Reset:** every output is 0 in the cycle after RST_N is sampled low. All FSMs, deb, stb, tick counter and drop_cnt are cleared.
- **Reset mid-handshake:** req drops immediately and the channel returns to IDLE.
- **Button held through reset:** yields one press after the debounce period.
- **Raw edge to deb change:** 2 cycles + DEBOUNCE_TICKS ticks. The first tick may arrive up to TICK_DIV cycles after the edge.
- **Event to req_x high:** 1 cycle (registered).
- **ack_x high to req_x low:** 1 cycle.
- **ack_x low to channel IDLE:** 1 cycle. The earliest next req is the cycle after that.
- **down_hold:** equals deb of buttenD, with no extra latency.
- **Glitch rejection:** a glitch shorter than DEBOUNCE_TICKS ticks never changes deb.

## Configuration
- **With AUTO_REPEAT_EN defined:** the repeat FSMs for left and right are instantiated.
- **Without it:** each press produces exactly one event, and holding the button produces nothing further.
- Turn and down behave identically in both builds.

## Test plan
Parameters for all scenarios: TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY=8, REPEAT_RATE=4, can_* = 1.
- **Reset:** assert RST_N=0 with all buttons high → all req = 0, drop_cnt = 0, down_hold = 0. Release reset → req_left rises after about 2 + 12 cycles.
- **Glitch:** a 6-cycle pulse on buttenL → deb never changes and no req. A 40-cycle press with ack returned 2 cycles after req → exactly one req_left pulse. req falls 1 cycle after ack.
- **Auto-repeat (AUTO_REPEAT_EN):** hold buttenR for 200 cycles with a fast ack → first req, second req about 32 cycles later, then one every 16 cycles. Release → no further req.
- **No ack:** hold ack_turn = 0 and press buttenT twice → req_turn stays high and drop_cnt = 1. Force 300 drops → drop_cnt = 255.
- **Gating:** can_left = 0 at the event cycle → no req_left and drop_cnt increments. Set can_left = 0 while req_left is already high → req stays high.
- **Reset mid-handshake:** pulse RST_N low for 1 cycle while in REQ → req = 0 in the next cycle and the channel is IDLE.
